// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, reads the instruction ROM and registers {PC+4, instruction, valid} for decode.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 256,
   parameter string       IMEM_FILE  = "imem.hex"
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] In_BranchPC,
   input  logic [31:0] In_JumpPC,
   input  logic        In_PCSrc,
   input  logic        In_Jump,
   input  logic        In_Stall,
   output logic [31:0] Out_PC,
   output logic [31:0] Out_IR,
   output logic        Out_Valid,
   output logic [31:0] Out_FetchCount
);

   localparam int unsigned AW = $clog2(IMEM_WORDS);

   logic [31:0] rom [IMEM_WORDS];

   logic [31:0] pc_q, pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_ir_q, out_ir_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] count_q, count_d;

   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] inst;
   logic        in_range;
   logic        redirect;

   assign pc_plus4 = pc_q + 32'd4;
   assign redirect = In_Jump | In_PCSrc;
   assign next_pc  = In_Jump ? In_JumpPC : (In_PCSrc ? In_BranchPC : pc_plus4);

   // Addresses past the end of the ROM read as NOP instead of aliasing.
   assign in_range = (pc_q >> (AW + 2)) == 32'd0;
   assign inst     = in_range ? rom[pc_q[AW+1:2]] : 32'h0;

   always_comb begin
      pc_d        = pc_q;
      out_pc_d    = out_pc_q;
      out_ir_d    = out_ir_q;
      out_valid_d = out_valid_q;
      count_d     = count_q;
      if (In_Stall) begin
         // hold everything; decode re-evaluates any redirect next cycle
      end else if (redirect) begin
         pc_d        = next_pc;
         out_pc_d    = 32'h0;
         out_ir_d    = 32'h0;
         out_valid_d = 1'b0;
      end else begin
         pc_d        = pc_plus4;
         out_pc_d    = pc_plus4;
         out_ir_d    = inst;
         out_valid_d = 1'b1;
         count_d     = count_q + 32'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc_q        <= RESET_PC;
         out_pc_q    <= 32'h0;
         out_ir_q    <= 32'h0;
         out_valid_q <= 1'b0;
         count_q     <= 32'h0;
      end else begin
         pc_q        <= pc_d;
         out_pc_q    <= out_pc_d;
         out_ir_q    <= out_ir_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
      end
   end

   assign Out_PC         = out_pc_q;
   assign Out_IR         = out_ir_q;
   assign Out_Valid      = out_valid_q;
   assign Out_FetchCount = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random stall/redirect/reset traffic,
// checked against a cycle-level architectural model of the fetch stage.
module tb_if_stage;

   localparam int unsigned WORDS = 32;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] In_BranchPC;
   logic [31:0] In_JumpPC;
   logic        In_PCSrc;
   logic        In_Jump;
   logic        In_Stall;
   logic [31:0] Out_PC;
   logic [31:0] Out_IR;
   logic        Out_Valid;
   logic [31:0] Out_FetchCount;

   if_stage #(
      .RESET_PC  (RPC),
      .IMEM_WORDS(WORDS),
      .IMEM_FILE ("")
   ) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .In_BranchPC   (In_BranchPC),
      .In_JumpPC     (In_JumpPC),
      .In_PCSrc      (In_PCSrc),
      .In_Jump       (In_Jump),
      .In_Stall      (In_Stall),
      .Out_PC        (Out_PC),
      .Out_IR        (Out_IR),
      .Out_Valid     (Out_Valid),
      .Out_FetchCount(Out_FetchCount)
   );

   always #5 Clk = ~Clk;

   logic [31:0] tb_rom [WORDS];
   int total = 0;
   int bad   = 0;

   // architectural model state
   logic [31:0] m_pc, m_out_pc, m_ir, m_cnt;
   logic        m_valid;

   function automatic logic [31:0] fetch(input logic [31:0] addr);
      if (addr < 4 * WORDS) return tb_rom[addr / 4];
      return 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given inputs, then compare every IF/ID output.
   task automatic step(input string tag, input logic rst, input logic stall, input logic pcsrc,
                       input logic jump, input logic [31:0] bpc, input logic [31:0] jpc);
      Rst = rst; In_Stall = stall; In_PCSrc = pcsrc; In_Jump = jump;
      In_BranchPC = bpc; In_JumpPC = jpc;
      @(posedge Clk);
      if (rst) begin
         m_pc = RPC; m_out_pc = 0; m_ir = 0; m_valid = 0; m_cnt = 0;
      end else if (stall) begin
         // nothing moves
      end else if (jump || pcsrc) begin
         m_pc = jump ? jpc : bpc;
         m_out_pc = 0; m_ir = 0; m_valid = 0;
      end else begin
         m_ir = fetch(m_pc);
         m_out_pc = m_pc + 4;
         m_valid = 1;
         m_cnt = m_cnt + 1;
         m_pc = m_pc + 4;
      end
      #1;
      chk({tag, ".ir"}, Out_IR, m_ir);
      chk({tag, ".pc"}, Out_PC, m_out_pc);
      chk({tag, ".valid"}, {31'h0, Out_Valid}, {31'h0, m_valid});
      chk({tag, ".count"}, Out_FetchCount, m_cnt);
   endtask

   task automatic run(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) begin
         tb_rom[i] = $urandom | 32'h1;
         dut.rom[i] = tb_rom[i];
      end
      m_pc = 0; m_out_pc = 0; m_ir = 0; m_valid = 0; m_cnt = 0;
      Rst = 1; In_Stall = 0; In_PCSrc = 0; In_Jump = 0; In_BranchPC = 0; In_JumpPC = 0;

      // reset and straight-line fetch of A..D
      step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) run("seq");
      chk("seq.count4", Out_FetchCount, 32'd4);
      chk("seq.lastpc", Out_PC, 32'd16);

      // branch taken while PC=8
      step("reset2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      run("br.pre"); run("br.pre");
      step("br.bubble", 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      run("br.target");
      chk("br.targetpc", Out_PC, 32'h24);
      chk("br.targetir", Out_IR, tb_rom[8]);

      // stall with a jump pending holds B
      step("reset3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      run("st.a"); run("st.b");
      for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h60);
      chk("stall.ir", Out_IR, tb_rom[1]);
      chk("stall.pc", Out_PC, 32'd8);
      run("st.c");
      chk("stall.resume", Out_IR, tb_rom[2]);

      // jump beats branch
      step("jb.bubble", 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h40);
      run("jb.target");
      chk("jb.pc", Out_PC, 32'h44);

      // jump past the ROM end reads NOP but stays valid
      step("oor.jump", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4 * WORDS);
      run("oor.a"); run("oor.b");
      chk("oor.ir", Out_IR, 32'h0);
      chk("oor.valid", {31'h0, Out_Valid}, 32'h1);

      // PC wrap at top of address space
      step("wrap.jump", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
      run("wrap.a");
      chk("wrap.pc", Out_PC, 32'h0);
      run("wrap.b");
      chk("wrap.ir", Out_IR, tb_rom[0]);

      // reset wins over stall and redirect
      step("rst.mix", 1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h48);
      run("rst.first");
      chk("rst.firstir", Out_IR, tb_rom[0]);
      chk("rst.firstpc", Out_PC, 32'h4);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         logic r, s, b, j;
         logic [31:0] bt, jt;
         r  = ($urandom_range(0, 49) == 0);
         s  = ($urandom_range(0, 3) == 0);
         b  = ($urandom_range(0, 5) == 0);
         j  = ($urandom_range(0, 7) == 0);
         bt = $urandom_range(0, 4 * WORDS + 16) & ~32'h3;
         jt = $urandom_range(0, 4 * WORDS + 16) | ($urandom_range(0, 3) == 0 ? 32'h2 : 32'h0);
         step("rand", r, s, b, j, bt, jt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
